// File: rtl/serial_data_sender.sv
// rtl/serial_data_sender.sv - serial frame transmitter: sync word, payload, optional CRC-8 (SERIAL_SENDER_CRC_EN)
module serial_data_sender #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_WORD  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  send_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  send_done,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(7);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
`ifdef SERIAL_SENDER_CRC_EN
        ST_CRC  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    load;
    logic                    out_d;
    logic                    valid_d;
    logic                    done_d;
    logic                    busy_d;
`ifdef SERIAL_SENDER_CRC_EN
    logic [7:0]              crc;
    logic                    crc_fb;
`endif

    // Outputs lag the state by one cycle, so DONE's edge is also edge N+1 and may accept the next frame.
    assign load = send_start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shreg <= data_in;
            end else if (state == ST_DATA) begin
                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef SERIAL_SENDER_CRC_EN
    assign crc_fb = crc[7] ^ shreg[DATA_WIDTH-1];

    // CRC-8 poly 0x07 accumulated bit-serially as the payload leaves, then shifted out itself.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            crc <= '0;
        end else if (load) begin
            crc <= '0;
        end else if (state == ST_DATA) begin
            crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end else if (state == ST_CRC) begin
            crc <= {crc[6:0], 1'b0};
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (send_start) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (cnt == LAST_BYTE) state_next = ST_DATA;
            end
            ST_DATA: begin
`ifdef SERIAL_SENDER_CRC_EN
                if (cnt == LAST_DATA) state_next = ST_CRC;
`else
                if (cnt == LAST_DATA) state_next = ST_DONE;
`endif
            end
`ifdef SERIAL_SENDER_CRC_EN
            ST_CRC: begin
                if (cnt == LAST_BYTE) state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_next = send_start ? ST_SYNC : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state)
            ST_SYNC: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                out_d   = SYNC_WORD[~cnt[2:0]];
            end
            ST_DATA: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                out_d   = shreg[DATA_WIDTH-1];
            end
`ifdef SERIAL_SENDER_CRC_EN
            ST_CRC: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                out_d   = crc[7];
            end
`endif
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            send_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            serial_out   <= out_d;
            serial_valid <= valid_d;
            send_done    <= done_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_data_sender.sv
// tb/tb_serial_data_sender.sv - scoreboard bench for serial_data_sender; honours SERIAL_SENDER_CRC_EN
module tb_serial_data_sender;

    localparam int DW = 16;
`ifdef SERIAL_SENDER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int N = 8 + DW + (CRC_EN ? 8 : 0);

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          send_start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          serial_out;
    logic          serial_valid;
    logic          send_done;
    logic          busy;

    serial_data_sender #(.DATA_WIDTH(DW), .SYNC_WORD(8'hA5)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .send_start   (send_start),
        .data_in      (data_in),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .send_done    (send_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // cyc holds k during cycle k, i.e. after edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit v;
        bit b;
        bit d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   last_acc = -1000;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual(valid,out,done,busy)=%b required=%b", name, cyc, act, req);
        end
    endtask

    // CRC as remainder of payload*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc8(input logic [DW-1:0] d);
        logic [DW+7:0] r;
        r = {d, 8'h00};
        for (int i = DW + 7; i >= 8; i--) begin
            if (r[i]) r = r ^ ((DW + 8)'(9'h107) << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic push_frame(input int s, input logic [DW-1:0] d);
        logic [7:0] sw;
        logic [7:0] cr;
        int         c;
        sw = 8'hA5;
        cr = crc8(d);
        c  = s + 1;
        for (int i = 7; i >= 0; i--) begin
            q.push_back('{c, 1'b1, sw[i], 1'b0});
            c++;
        end
        for (int i = DW - 1; i >= 0; i--) begin
            q.push_back('{c, 1'b1, d[i], 1'b0});
            c++;
        end
        if (CRC_EN) begin
            for (int i = 7; i >= 0; i--) begin
                q.push_back('{c, 1'b1, cr[i], 1'b0});
                c++;
            end
        end
        q.push_back('{c, 1'b0, 1'b0, 1'b1});
    endtask

    // Drive send_start so it is sampled at edge e; call at a negedge with e > cyc.
    task automatic start_at(input int e, input logic [DW-1:0] d);
        while (cyc + 1 < e) @(negedge clk);
        send_start = 1'b1;
        data_in    = d;
        if (e >= last_acc + N + 1) begin
            push_frame(e, d);
            last_acc = e;
        end
        @(negedge clk);
        send_start = 1'b0;
        data_in    = DW'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] d);
        start_at(cyc + 1, d);
    endtask

    always @(negedge clk) begin
        logic [3:0] req;
        exp_t       e;
        req = 4'b0000;
        if (rst_l && q.size() > 0 && q[0].cyc == cyc) begin
            e   = q.pop_front();
            req = {e.v, e.b, e.d, 1'b1};
        end
        check("frame", {serial_valid, serial_out, send_done, busy}, req);
    end

    initial begin
        int s;
        int e1;
        int e2;

        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);

        send(16'h1234);
        repeat (N + 4) @(negedge clk);

        send(16'h0001);
        repeat (N + 4) @(negedge clk);
        send(16'h0000);
        repeat (N + 4) @(negedge clk);

        s = cyc + 1;
        send(16'hFFFF);
        start_at(s + 5, DW'($urandom));
        start_at(s + 24, DW'($urandom));
        repeat (N + 6) @(negedge clk);

        s = cyc + 1;
        send(16'hAAAA);
        start_at(s + N + 1, 16'h5555);
        repeat (N + 6) @(negedge clk);

        s = cyc + 1;
        send(DW'($urandom));
        while (cyc != s + 12) @(negedge clk);
        #1;
        rst_l = 1'b0;
        q.delete();
        last_acc = -1000;
        #1;
        check("abort", {serial_valid, serial_out, send_done, busy}, 4'b0000);
        while (cyc != s + 14) @(negedge clk);
        #1;
        rst_l = 1'b1;
        @(negedge clk);
        send(16'hC3E1);
        repeat (N + 4) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                e1 = last_acc + int'($urandom_range(1, N));
                if (e1 <= cyc) e1 = cyc + 1;
                start_at(e1, DW'($urandom));
            end
            e2 = last_acc + N + 1 + int'($urandom_range(0, 3));
            if (e2 <= cyc) e2 = cyc + 1;
            start_at(e2, DW'($urandom));
        end

        repeat (N + 6) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending entries required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
